adc_serial_reader: RTL and testbench

Serial-ADC front end for the audio spectrum analyzer. It replaces the tied-off ADC pins (`adc_cs`/`adc_clk`/`adc_dat`) with a real reader for an ADC081S101-class 8-bit serial ADC. It generates chip-select and serial clock at a fixed sample rate and shifts in one 16-bit frame per conversion. Each conversion yields an 8-bit sample with a one-cycle valid strobe, which feeds the FFT input in place of the simulated test signal.

---
 rtl/adc_serial_reader_pkg.sv | 8 +
 rtl/adc_serial_reader_if.sv | 8 +
 rtl/adc_serial_reader_rate_tick.sv | 17 +
 rtl/adc_serial_reader.sv | 86 ++++++++
 tb/tb_adc_serial_reader.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/adc_serial_reader_pkg.sv
// adc_reader_pkg: state encoding and 16-bit frame layout shared by the serial ADC reader.
package adc_reader_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD} adc_state_t;
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_LEAD_BITS  = 3;
  localparam int ADC_DATA_BITS  = 8;
  localparam int ADC_DATA_LSB   = ADC_LEAD_BITS;
endpackage

// File: rtl/adc_serial_reader_if.sv
// adc_serial_reader_if: three-wire serial ADC link (chip select, serial clock, data).
interface adc_serial_reader_if;
  logic adc_cs;
  logic adc_clk;
  logic adc_dat;
  modport master(output adc_cs, output adc_clk, input adc_dat);
  modport slave(input adc_cs, input adc_clk, output adc_dat);
endinterface

// File: rtl/adc_serial_reader_rate_tick.sv
// adc_rate_tick: sample-period counter, held at zero while disabled; fires a start when the reader is idle.
module adc_rate_tick #(
  parameter int SAMPLE_PERIOD = 375
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic idle,
  output logic tick
);
  localparam int CW = $clog2(SAMPLE_PERIOD);
  logic [CW-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= (!enable || count == CW'(SAMPLE_PERIOD - 1)) ? '0 : count + 1'b1;
  assign tick = enable && count == '0 && idle;
endmodule

// File: rtl/adc_serial_reader.sv
// adc_serial_reader: ADC081S101-class reader, one 16-bit frame per conversion, 8-bit sample out.
// Define ADC_FRAME_CHECK_EN to reject frames whose three leading zeros are violated.
module adc_serial_reader
  import adc_reader_pkg::*;
#(
  parameter int HALF_DIV      = 3,
  parameter int SAMPLE_PERIOD = 375
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  adc_serial_reader_if.master      bus,
  output logic [ADC_DATA_BITS-1:0] sample,
  output logic                     sample_valid,
  output logic                     frame_err,
  output logic                     busy
);
  localparam int PW = HALF_DIV > 1 ? $clog2(HALF_DIV) : 1;
  localparam int BW = $clog2(ADC_FRAME_BITS + 1);
  adc_state_t state;
  logic [PW-1:0] ph;
  logic [BW-1:0] bits;
  logic [ADC_FRAME_BITS-1:0] sr;
  logic cs, sclk, tick, ph_end, last_bit;
  adc_rate_tick #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_rate (
    .clk(clk), .rst_n(rst_n), .enable(enable), .idle(state == IDLE), .tick(tick)
  );
  assign ph_end = ph == PW'(HALF_DIV - 1);
  assign last_bit = bits == BW'(ADC_FRAME_BITS);
  assign bus.adc_cs = cs;
  assign bus.adc_clk = sclk;
  assign busy = ~cs;
  // adc_dat is sampled unsynchronized: it was launched HALF_DIV cycles earlier on our own falling edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ph <= '0;
      bits <= '0;
      sr <= '0;
      cs <= 1'b1;
      sclk <= 1'b1;
      sample <= '0;
      sample_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err <= 1'b0;
      ph <= (state == IDLE || ph_end) ? '0 : ph + 1'b1;
      case (state)
        IDLE: if (tick) begin
          state <= SETUP;
          cs <= 1'b0;
          bits <= '0;
        end
        SETUP: if (ph_end) begin
          state <= LOW;
          sclk <= 1'b0;
        end
        LOW: if (ph_end) begin
          state <= HIGH;
          sclk <= 1'b1;
          bits <= bits + 1'b1;
          sr <= ADC_FRAME_BITS'({sr, bus.adc_dat});
        end
        HIGH: if (ph_end) begin
          state <= last_bit ? HOLD : LOW;
          sclk <= last_bit;
        end
        HOLD: if (ph_end) begin
          state <= IDLE;
          cs <= 1'b1;
`ifdef ADC_FRAME_CHECK_EN
          if (|sr[ADC_FRAME_BITS-1 -: ADC_LEAD_BITS]) frame_err <= 1'b1;
          else begin
            sample <= sr[ADC_FRAME_BITS-1-ADC_DATA_LSB -: ADC_DATA_BITS];
            sample_valid <= 1'b1;
          end
`else
          sample <= sr[ADC_FRAME_BITS-1-ADC_DATA_LSB -: ADC_DATA_BITS];
          sample_valid <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_adc_serial_reader.sv
// tb_adc_serial_reader: serial ADC model plus scoreboard of expected conversion results.
module tb_adc_serial_reader;
  localparam int HD = 3;
  localparam int SP = 375;
  localparam int LAT = 34 * HD + 1;
  typedef struct packed {logic err; logic [7:0] data;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [7:0] sample;
  logic sample_valid, frame_err, busy;
  adc_serial_reader_if bus();
  adc_serial_reader #(.HALF_DIV(HD), .SAMPLE_PERIOD(SP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus.master),
    .sample(sample), .sample_valid(sample_valid), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  int compared = 0, mismatched = 0;
  logic [15:0] frames[$];
  exp_t sb[$];
  logic [15:0] cur = '0;
  logic [7:0] last_good = 8'h00;
  int bitn = 0;
  initial bus.adc_dat = 1'b0;
  always @(negedge bus.adc_cs) begin
    cur = frames.size() > 0 ? frames.pop_front() : 16'h0000;
    bitn = 0;
  end
  always @(negedge bus.adc_clk)
    if (!bus.adc_cs && bitn < 16) begin
      #1;
      bus.adc_dat = cur[15 - bitn];
      bitn++;
    end
  int cs_low = 0, rises = 0, low_run = 0, phase_bad = 0, valids = 0, errs = 0, busy_bad = 0;
  logic prev_clk = 1'b1;
  always @(negedge clk) begin
    if (!bus.adc_cs) cs_low++;
    if (busy !== !bus.adc_cs) busy_bad++;
    if (!bus.adc_clk) low_run++;
    else if (!prev_clk) begin
      rises++;
      if (low_run != HD) phase_bad++;
      low_run = 0;
    end
    prev_clk = bus.adc_clk;
    if (sample_valid) valids++;
    if (frame_err) errs++;
  end
  task automatic push_frame(input logic [2:0] lead, input logic [7:0] d, input logic [4:0] tail);
    frames.push_back({lead, d, tail});
`ifdef ADC_FRAME_CHECK_EN
    if (lead != 3'b000) sb.push_back({1'b1, last_good});
    else begin
      sb.push_back({1'b0, d});
      last_good = d;
    end
`else
    sb.push_back({1'b0, d});
    last_good = d;
`endif
  endtask
  task automatic wait_strobe(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && !frame_err && n < budget);
    if (!sample_valid && !frame_err) n = -1;
  endtask
  task automatic test_reset();
    int v0, e0, l0;
    repeat (3) @(negedge clk);
    #1;
    compared++; if (bus.adc_cs !== 1'b1) begin mismatched++; $display("FAIL reset_cs: got %b want 1", bus.adc_cs); end
    compared++; if (bus.adc_clk !== 1'b1) begin mismatched++; $display("FAIL reset_sclk: got %b want 1", bus.adc_clk); end
    compared++; if (sample !== 8'h00) begin mismatched++; $display("FAIL reset_sample: got %h want 00", sample); end
    compared++; if ({sample_valid, frame_err, busy} !== 3'b000) begin mismatched++; $display("FAIL reset_strobes: got %b want 000", {sample_valid, frame_err, busy}); end
    rst_n = 1'b1;
    v0 = valids; e0 = errs; l0 = cs_low;
    repeat (1000) @(negedge clk);
    #1;
    compared++; if (valids - v0 + errs - e0 !== 0) begin mismatched++; $display("FAIL idle_strobes: got %0d want 0", valids - v0 + errs - e0); end
    compared++; if (cs_low - l0 !== 0) begin mismatched++; $display("FAIL idle_cs_low: got %0d cycles want 0", cs_low - l0); end
    compared++; if ({bus.adc_cs, bus.adc_clk, sample} !== {2'b11, 8'h00}) begin mismatched++; $display("FAIL idle_outputs: got %b want 1100000000", {bus.adc_cs, bus.adc_clk, sample}); end
  endtask
  task automatic test_single();
    int n, l0, r0, p0;
    exp_t x;
    push_frame(3'b000, 8'hA5, 5'b00000);
    @(negedge clk);
    #1;
    l0 = cs_low; r0 = rises; p0 = phase_bad;
    enable = 1'b1;
    wait_strobe(LAT + 50, n);
    compared++; if (n !== LAT) begin mismatched++; $display("FAIL single_latency: got %0d want %0d", n, LAT); end
    compared++; if (bus.adc_cs !== 1'b1) begin mismatched++; $display("FAIL single_cs_at_valid: got %b want 1", bus.adc_cs); end
    if (n > 0 && sb.size() > 0) begin
      x = sb.pop_front();
      compared++; if ({frame_err, sample_valid} !== {x.err, !x.err}) begin mismatched++; $display("FAIL single_flags: got %b want %b", {frame_err, sample_valid}, {x.err, !x.err}); end
      compared++; if (sample !== x.data) begin mismatched++; $display("FAIL single_sample: got %h want %h", sample, x.data); end
    end
    #1;
    enable = 1'b0;
    compared++; if (cs_low - l0 !== LAT - 1) begin mismatched++; $display("FAIL single_cs_low: got %0d want %0d", cs_low - l0, LAT - 1); end
    compared++; if (rises - r0 !== 16) begin mismatched++; $display("FAIL single_rises: got %0d want 16", rises - r0); end
    compared++; if (phase_bad - p0 !== 0) begin mismatched++; $display("FAIL single_phase: got %0d bad low phases want 0", phase_bad - p0); end
  endtask
  task automatic test_back_to_back();
    int n;
    exp_t x;
    push_frame(3'b000, 8'h00, 5'b11011);
    push_frame(3'b000, 8'hFF, 5'b00100);
    @(negedge clk);
    #1;
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_strobe(SP + 50, n);
      compared++; if (n !== (k == 0 ? LAT : SP)) begin mismatched++; $display("FAIL b2b_gap%0d: got %0d want %0d", k, n, k == 0 ? LAT : SP); end
      if (n > 0 && sb.size() > 0) begin
        x = sb.pop_front();
        compared++; if ({frame_err, sample_valid} !== {x.err, !x.err}) begin mismatched++; $display("FAIL b2b_flags%0d: got %b want %b", k, {frame_err, sample_valid}, {x.err, !x.err}); end
        compared++; if (sample !== x.data) begin mismatched++; $display("FAIL b2b_sample%0d: got %h want %h", k, sample, x.data); end
      end
    end
    #1;
    enable = 1'b0;
  endtask
  task automatic test_lead_bits();
    int n;
    exp_t x;
    push_frame(3'b000, 8'h11, 5'b00000);
    push_frame(3'b100, 8'h3C, 5'b00000);
    @(negedge clk);
    #1;
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_strobe(SP + 50, n);
      compared++; if (n !== (k == 0 ? LAT : SP)) begin mismatched++; $display("FAIL lead_gap%0d: got %0d want %0d", k, n, k == 0 ? LAT : SP); end
      if (n > 0 && sb.size() > 0) begin
        x = sb.pop_front();
        compared++; if ({frame_err, sample_valid} !== {x.err, !x.err}) begin mismatched++; $display("FAIL lead_flags%0d: got %b want %b", k, {frame_err, sample_valid}, {x.err, !x.err}); end
        compared++; if (sample !== x.data) begin mismatched++; $display("FAIL lead_sample%0d: got %h want %h", k, sample, x.data); end
      end
    end
    #1;
    enable = 1'b0;
  endtask
  task automatic test_enable_drop();
    int n, l0, v0;
    exp_t x;
    push_frame(3'b000, 8'h5A, 5'b10101);
    @(negedge clk);
    #1;
    enable = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    enable = 1'b0;
    wait_strobe(200, n);
    compared++; if (n !== LAT - 50) begin mismatched++; $display("FAIL drop_latency: got %0d want %0d", n, LAT - 50); end
    if (n > 0 && sb.size() > 0) begin
      x = sb.pop_front();
      compared++; if ({frame_err, sample_valid} !== {x.err, !x.err}) begin mismatched++; $display("FAIL drop_flags: got %b want %b", {frame_err, sample_valid}, {x.err, !x.err}); end
      compared++; if (sample !== x.data) begin mismatched++; $display("FAIL drop_sample: got %h want %h", sample, x.data); end
    end
    #1;
    l0 = cs_low; v0 = valids;
    repeat (2000) @(negedge clk);
    #1;
    compared++; if (cs_low - l0 !== 0) begin mismatched++; $display("FAIL drop_no_restart: got %0d cs-low cycles want 0", cs_low - l0); end
    compared++; if (valids - v0 !== 0) begin mismatched++; $display("FAIL drop_no_strobe: got %0d want 0", valids - v0); end
    compared++; if (busy_bad !== 0) begin mismatched++; $display("FAIL busy_track: got %0d cycles busy != ~adc_cs want 0", busy_bad); end
  endtask
  task automatic test_reset_mid_frame();
    int n, v0;
    exp_t x;
    frames.push_back({3'b000, 8'h77, 5'b00000});
    @(negedge clk);
    #1;
    enable = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    compared++; if (bus.adc_cs !== 1'b0) begin mismatched++; $display("FAIL mid_cs_before: got %b want 0", bus.adc_cs); end
    v0 = valids;
    #1;
    rst_n = 1'b0;
    last_good = 8'h00;
    #1;
    compared++; if ({bus.adc_cs, bus.adc_clk, busy} !== 3'b110) begin mismatched++; $display("FAIL mid_async: got %b want 110", {bus.adc_cs, bus.adc_clk, busy}); end
    compared++; if ({sample, sample_valid} !== 9'h000) begin mismatched++; $display("FAIL mid_sample: got %h want 000", {sample, sample_valid}); end
    repeat (5) @(negedge clk);
    #1;
    compared++; if (valids - v0 !== 0) begin mismatched++; $display("FAIL mid_no_strobe: got %0d want 0", valids - v0); end
    push_frame(3'b000, 8'hC3, 5'b00000);
    rst_n = 1'b1;
    wait_strobe(LAT + 50, n);
    compared++; if (n !== LAT) begin mismatched++; $display("FAIL mid_restart: got %0d want %0d", n, LAT); end
    if (n > 0 && sb.size() > 0) begin
      x = sb.pop_front();
      compared++; if (sample !== x.data) begin mismatched++; $display("FAIL mid_sample_after: got %h want %h", sample, x.data); end
    end
    #1;
    enable = 1'b0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_lead_bits();
    test_enable_drop();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
